bank_queue_manager: RTL and testbench

BANK_QUEUE_MANAGER -- requirements
Module: bank_queue_manager

---
 rtl/bank_queue_manager_if.sv | 30 +++
 rtl/bank_queue_manager.sv | 148 ++++++++++++++
 tb/tb_bank_queue_manager.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bank_queue_manager_if.sv
// Customer-queue signal bundle: photocells, teller count and error clear in;
// occupancy, status flags and wait-time estimate out.
interface bank_queue_manager_if #(
    parameter int CW = 3,
    parameter int TW = 3,
    parameter int WW = 8
);
    logic          BPH;
    logic          FPH;
    logic [TW-1:0] tellers;
    logic          alarm_clr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          alarm;
    logic          uflow;
    logic          teller_err;
    logic [WW-1:0] wtime;
    logic          wtime_valid;

    modport master (
        output BPH, FPH, tellers, alarm_clr,
        input  count, full, empty, alarm, uflow, teller_err, wtime, wtime_valid
    );

    modport slave (
        input  BPH, FPH, tellers, alarm_clr,
        output count, full, empty, alarm, uflow, teller_err, wtime, wtime_valid
    );
endinterface

// File: rtl/bank_queue_manager.sv
// Bank queue occupancy tracker driven by two photocells, with a serial
// divider that estimates the waiting time from occupancy and active tellers.
module bank_queue_manager #(
    parameter int DEPTH    = 7,
    parameter int CW       = 3,
    parameter int TW       = 3,
    parameter int SVC_TIME = 3,
    parameter int WW       = 8
) (
    input logic                 clock,
    input logic                 clear_n,
    bank_queue_manager_if.slave bus
);
    // Divider operands must hold count + tellers - 1 without wrapping.
    localparam int RW = $clog2(DEPTH + (1 << TW));
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   WMAX    = 32'((64'd1 << WW) - 64'd1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV} state_t;

    logic [2:0]    bph_sync, fph_sync;
    logic          arrive, depart;
    logic [CW-1:0] count_r, count_nxt;
    logic          full_r, empty_r, alarm_r, uflow_r, teller_err_r;
    logic          alarm_set, uflow_set;

    state_t        state, state_nxt;
    logic [CW-1:0] snap_count;
    logic [TW-1:0] snap_tellers;
    logic [RW-1:0] rem, q;
    logic [WW-1:0] wtime_r, wtime_sat;
    logic          wtime_valid_r;
    logic          changed;
    logic [31:0]   prod;

    // Stages 0/1 synchronise, stage 2 is the previous level for edge detection.
    assign arrive = bph_sync[1] & ~bph_sync[2];
    assign depart = fph_sync[1] & ~fph_sync[2];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            bph_sync <= '0;
            fph_sync <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            bph_sync <= {bph_sync[1:0], bus.BPH};
            fph_sync <= {fph_sync[1:0], bus.FPH};
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        count_nxt = count_r;
        alarm_set = 1'b0;
        uflow_set = 1'b0;
        unique case ({arrive, depart})
            2'b10: if (count_r == DEPTH_C) alarm_set = 1'b1;
                   else count_nxt = count_r + CW'(1);
            2'b01: if (count_r == '0) uflow_set = 1'b1;
                   else count_nxt = count_r - CW'(1);
            default: ;
        endcase
    end

    // Flags come from the next count so they line up with the count register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_r      <= '0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            alarm_r      <= 1'b0;
            uflow_r      <= 1'b0;
            teller_err_r <= 1'b0;
        end else begin
            count_r      <= count_nxt;
            full_r       <= (count_nxt == DEPTH_C);
            empty_r      <= (count_nxt == '0);
            teller_err_r <= (bus.tellers == '0);
            alarm_r      <= alarm_set | (alarm_r & ~bus.alarm_clr);
            uflow_r      <= uflow_set | (uflow_r & ~bus.alarm_clr);
        end
    end

    assign changed   = (count_r != snap_count) || (bus.tellers != snap_tellers);
    assign prod      = 32'(q) * 32'(SVC_TIME);
    assign wtime_sat = (prod > WMAX) ? '1 : prod[WW-1:0];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state <= LOAD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (changed) state_nxt = LOAD;
            LOAD: state_nxt = (bus.tellers == '0) ? IDLE : DIV;
            DIV:  if (changed) state_nxt = LOAD;
                  else if (rem < RW'(snap_tellers)) state_nxt = IDLE;
            default: state_nxt = LOAD;
        endcase
    end

    // wtime is only written on completion, so an aborted pass leaves the old estimate.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            snap_count    <= '0;
            snap_tellers  <= '0;
            rem           <= '0;
            q             <= '0;
            wtime_r       <= '0;
            wtime_valid_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (changed) wtime_valid_r <= 1'b0;
                LOAD: begin
                    snap_count   <= count_r;
                    snap_tellers <= bus.tellers;
                    rem          <= RW'(count_r) + RW'(bus.tellers) - RW'(1);
                    q            <= '0;
                    if (bus.tellers == '0) begin
                        wtime_r       <= '1;
                        wtime_valid_r <= 1'b1;
                    end
                end
                DIV: if (!changed) begin
                    if (rem >= RW'(snap_tellers)) begin
                        rem <= rem - RW'(snap_tellers);
                        q   <= q + RW'(1);
                    end else begin
                        wtime_r       <= wtime_sat;
                        wtime_valid_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.count       = count_r;
    assign bus.full        = full_r;
    assign bus.empty       = empty_r;
    assign bus.alarm       = alarm_r;
    assign bus.uflow       = uflow_r;
    assign bus.teller_err  = teller_err_r;
    assign bus.wtime       = wtime_r;
    assign bus.wtime_valid = wtime_valid_r;
endmodule

// File: tb/tb_bank_queue_manager.sv
// Directed bench for bank_queue_manager: photocell pulses, flag behaviour,
// wait-time recompute/abort and asynchronous reset, against hand-worked values.
module tb_bank_queue_manager;
    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    bank_queue_manager_if #(.CW(3), .TW(3), .WW(8)) bus ();

    bank_queue_manager #(
        .DEPTH(7), .CW(3), .TW(3), .SVC_TIME(3), .WW(8)
    ) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clean photocell pulse; returns three cycles after the count update edge.
    task automatic pulse(input logic b, input logic f);
        @(negedge clock);
        bus.BPH = b;
        bus.FPH = f;
        repeat (2) @(negedge clock);
        bus.BPH = 1'b0;
        bus.FPH = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (bus.wtime_valid) seen = 1'b1;
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
    endtask

    task automatic clear_flags();
        @(negedge clock);
        bus.alarm_clr = 1'b1;
        @(negedge clock);
        bus.alarm_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.BPH = 1'b0;
        bus.FPH = 1'b0;
        bus.tellers = 3'd2;
        bus.alarm_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full",  32'(bus.full), 0);
        check("rst_alarm", 32'(bus.alarm), 0);
        check("rst_uflow", 32'(bus.uflow), 0);
        check("rst_wtime", 32'(bus.wtime), 0);
        check("rst_valid", 32'(bus.wtime_valid), 0);
        clear_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("boot_wtime", 32'(bus.wtime), 0);
        check("boot_valid", 32'(bus.wtime_valid), 1);
        check("boot_terr",  32'(bus.teller_err), 0);

        // Three-edge latency from BPH rise to count update
        @(negedge clock);
        bus.BPH = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("lat_edge2", 32'(bus.count), 0);
        @(posedge clock);
        #1;
        check("lat_edge3", 32'(bus.count), 1);
        @(negedge clock);
        bus.BPH = 1'b0;
        repeat (3) @(negedge clock);

        // Five arrivals with two tellers: ceil(5/2)*3 = 9
        for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
        check("five_count", 32'(bus.count), 5);
        wait_valid("five", 8);
        check("five_wtime", 32'(bus.wtime), 9);
        check("five_empty", 32'(bus.empty), 0);

        // One teller: 5*3 = 15
        @(negedge clock);
        bus.tellers = 3'd1;
        wait_valid("t1", 12);
        check("t1_wtime", 32'(bus.wtime), 15);

        // Departure to 4, then tellers 1->3 while dividing: abort, ceil(4/3)*3 = 6
        pulse(1'b0, 1'b1);
        check("abort_count", 32'(bus.count), 4);
        check("abort_low",  32'(bus.wtime_valid), 0);
        check("abort_hold", 32'(bus.wtime), 15);
        bus.tellers = 3'd3;
        wait_valid("abort", 12);
        check("abort_wtime", 32'(bus.wtime), 6);

        // Fill to 7, reject one more
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        check("fill_count", 32'(bus.count), 7);
        check("fill_full",  32'(bus.full), 1);
        check("fill_alarm", 32'(bus.alarm), 0);
        pulse(1'b1, 1'b0);
        check("ovf_count", 32'(bus.count), 7);
        check("ovf_alarm", 32'(bus.alarm), 1);
        clear_flags();
        check("clr_alarm", 32'(bus.alarm), 0);
        check("clr_full",  32'(bus.full), 1);

        // Rejected arrival coinciding with alarm_clr: set wins
        @(negedge clock);
        bus.BPH = 1'b1;
        repeat (2) @(negedge clock);
        bus.BPH = 1'b0;
        bus.alarm_clr = 1'b1;
        @(negedge clock);
        bus.alarm_clr = 1'b0;
        check("setwin_alarm", 32'(bus.alarm), 1);
        repeat (2) @(negedge clock);
        clear_flags();

        // Simultaneous arrival and departure at full
        pulse(1'b1, 1'b1);
        check("both_full_count", 32'(bus.count), 7);
        check("both_full_alarm", 32'(bus.alarm), 0);

        // Drain, then underflow
        for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1);
        check("drain_count", 32'(bus.count), 0);
        check("drain_empty", 32'(bus.empty), 1);
        check("drain_uflow", 32'(bus.uflow), 0);
        pulse(1'b0, 1'b1);
        check("unf_count", 32'(bus.count), 0);
        check("unf_uflow", 32'(bus.uflow), 1);
        clear_flags();
        check("clr_uflow", 32'(bus.uflow), 0);
        pulse(1'b1, 1'b1);
        check("both_empty_count", 32'(bus.count), 0);
        check("both_empty_uflow", 32'(bus.uflow), 0);
        check("both_empty_alarm", 32'(bus.alarm), 0);

        // No tellers
        @(negedge clock);
        bus.tellers = 3'd0;
        wait_valid("t0", 6);
        check("t0_terr",  32'(bus.teller_err), 1);
        check("t0_wtime", 32'(bus.wtime), 255);

        // Reset in the middle of a division at count 6
        @(negedge clock);
        bus.tellers = 3'd1;
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
        check("pre_count", 32'(bus.count), 6);
        check("pre_valid", 32'(bus.wtime_valid), 0);
        #2;
        clear_n = 1'b0;
        #1;
        check("mid_count", 32'(bus.count), 0);
        check("mid_empty", 32'(bus.empty), 1);
        check("mid_full",  32'(bus.full), 0);
        check("mid_wtime", 32'(bus.wtime), 0);
        check("mid_valid", 32'(bus.wtime_valid), 0);
        @(negedge clock);
        clear_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("post_wtime", 32'(bus.wtime), 0);
        check("post_valid", 32'(bus.wtime_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
